// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INTR, runs the two-pulse INTA handshake and
// owns the in-service register, EOI handling and priority rotation.
module interrupt_ack_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned SPUR_LEVEL  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       rotate_on_aeoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic [7:0] clear_irr,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic       ack_error
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_ACK1     = 3'd2,
        ST_ACK1_REL = 3'd3,
        ST_ACK2     = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);
    localparam logic [2:0] SPUR_C    = 3'(SPUR_LEVEL);

    function automatic logic [2:0] encode8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Returns {found, level}: first set ISR bit scanning from the level after the rotation point.
    function automatic logic [3:0] ns_pick(input logic [7:0] isr, input logic [7:0] hlis);
        logic [2:0] start;
        logic [2:0] cand;
        logic [2:0] lvl;
        logic       found;
        start = (hlis == 8'h00) ? 3'd0 : (encode8(hlis) + 3'd1);
        found = 1'b0;
        lvl   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = start + 3'(k);
            if (!found && isr[cand]) begin
                found = 1'b1;
                lvl   = cand;
            end else begin
                found = found;
            end
        end
        return {found, lvl};
    endfunction

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [7:0] timer_q, timer_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] hlis_q, hlis_d;
    logic       int_out_q, int_out_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_en_q, data_en_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic       ack_error_q, ack_error_d;

    logic       inta_fall_s, inta_rise_s, timeout_s, in_ack1_s;
    logic       enter_ack1_s, req_spur_s, ack2_exit_s, aeoi_s;
    logic [2:0] req_lvl_s;
    logic [3:0] ns_pick_s;
    logic       eoi_hit_s;
    logic [2:0] eoi_lvl_s;
    logic [7:0] set_mask_s, eoi_clr_s, aeoi_clr_s;

    assign inta_fall_s  = inta_prev_q & ~inta_n;
    assign inta_rise_s  = ~inta_prev_q & inta_n;
    assign in_ack1_s    = (state_q == ST_ACK1) || (state_q == ST_ACK1_REL);
    assign timeout_s    = in_ack1_s && (timer_q == TIMEOUT_C);
    assign enter_ack1_s = (state_q == ST_REQ) && inta_fall_s;
    assign req_spur_s   = (interrupt == 8'h00);
    assign req_lvl_s    = req_spur_s ? SPUR_C : encode8(interrupt);
    assign ack2_exit_s  = (state_q == ST_ACK2) && inta_rise_s;
    assign aeoi_s       = ack2_exit_s && auto_eoi && !spur_q;
    assign ns_pick_s    = ns_pick(isr_q, hlis_q);

    // Next-state logic of the acknowledge handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (interrupt != 8'h00) state_d = ST_REQ;
                else                    state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (inta_fall_s)                state_d = ST_ACK1;
                else if (interrupt == 8'h00)    state_d = ST_IDLE;
                else                            state_d = ST_REQ;
            end
            ST_ACK1: begin
                if (timeout_s)        state_d = ST_IDLE;
                else if (inta_rise_s) state_d = ST_ACK1_REL;
                else                  state_d = ST_ACK1;
            end
            ST_ACK1_REL: begin
                if (timeout_s)        state_d = ST_IDLE;
                else if (inta_fall_s) state_d = ST_ACK2;
                else                  state_d = ST_ACK1_REL;
            end
            ST_ACK2: begin
                if (inta_rise_s) state_d = ST_IDLE;
                else             state_d = ST_ACK2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ISR / rotation / latched level: EOI clears act on the old ISR, the INTA1 set is ORed last.
    always_comb begin
        lvl_d      = lvl_q;
        spur_d     = spur_q;
        timer_d    = timer_q;
        set_mask_s = 8'h00;
        if (enter_ack1_s) begin
            lvl_d   = req_lvl_s;
            spur_d  = req_spur_s;
            timer_d = 8'h00;
            if (!req_spur_s) set_mask_s = 8'h01 << req_lvl_s;
            else             set_mask_s = 8'h00;
        end else if (in_ack1_s) begin
            timer_d = timer_q + 8'h01;
        end else begin
            timer_d = timer_q;
        end

        if (eoi_valid && eoi_specific) begin
            eoi_hit_s = 1'b1;
            eoi_lvl_s = eoi_level;
        end else if (eoi_valid) begin
            eoi_hit_s = ns_pick_s[3];
            eoi_lvl_s = ns_pick_s[2:0];
        end else begin
            eoi_hit_s = 1'b0;
            eoi_lvl_s = 3'd0;
        end

        if (eoi_hit_s) eoi_clr_s = 8'h01 << eoi_lvl_s;
        else           eoi_clr_s = 8'h00;
        if (aeoi_s)    aeoi_clr_s = 8'h01 << lvl_q;
        else           aeoi_clr_s = 8'h00;

        isr_d = (isr_q & ~eoi_clr_s & ~aeoi_clr_s) | set_mask_s;

        if (aeoi_s && rotate_on_aeoi)      hlis_d = 8'h01 << lvl_q;
        else if (eoi_hit_s && eoi_rotate)  hlis_d = 8'h01 << eoi_lvl_s;
        else                               hlis_d = hlis_q;
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        int_out_d  = 1'b0;
        data_en_d  = 1'b0;
        data_out_d = 8'h00;
        case (state_d)
            ST_REQ, ST_ACK1: int_out_d = 1'b1;
            ST_ACK2: begin
                data_en_d  = 1'b1;
                data_out_d = {vector_base, lvl_d};
            end
            ST_IDLE, ST_ACK1_REL: int_out_d = 1'b0;
            default: int_out_d = 1'b0;
        endcase
        clear_irr_d = set_mask_s;
        ack_error_d = timeout_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inta_prev_q <= 1'b1;
            timer_q     <= 8'h00;
            lvl_q       <= 3'd0;
            spur_q      <= 1'b0;
            isr_q       <= 8'h00;
            hlis_q      <= 8'h00;
            int_out_q   <= 1'b0;
            data_out_q  <= 8'h00;
            data_en_q   <= 1'b0;
            clear_irr_q <= 8'h00;
            ack_error_q <= 1'b0;
        end else begin
            inta_prev_q <= inta_n;
            timer_q     <= timer_d;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
            isr_q       <= isr_d;
            hlis_q      <= hlis_d;
            int_out_q   <= int_out_d;
            data_out_q  <= data_out_d;
            data_en_q   <= data_en_d;
            clear_irr_q <= clear_irr_d;
            ack_error_q <= ack_error_d;
        end
    end

    assign int_out                  = int_out_q;
    assign data_out                 = data_out_q;
    assign data_out_en              = data_en_q;
    assign clear_irr                = clear_irr_q;
    assign in_service_register      = isr_q;
    assign highest_level_in_service = hlis_q;
    assign ack_error                = ack_error_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Randomised scoreboard bench for interrupt_ack_sequencer: a transaction-level model predicts
// ISR/rotation and the vector, clear and error events that a monitor checks.
module tb_interrupt_ack_sequencer;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] interrupt = 8'h00;
    logic       inta_n = 1'b1;
    logic [4:0] vector_base = 5'h00;
    logic       auto_eoi = 1'b0;
    logic       rotate_on_aeoi = 1'b0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       eoi_rotate = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [7:0] clear_irr;
    logic [7:0] isr;
    logic [7:0] hlis;
    logic       ack_error;

    interrupt_ack_sequencer dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .interrupt                (interrupt),
        .inta_n                   (inta_n),
        .vector_base              (vector_base),
        .auto_eoi                 (auto_eoi),
        .rotate_on_aeoi           (rotate_on_aeoi),
        .eoi_valid                (eoi_valid),
        .eoi_specific             (eoi_specific),
        .eoi_rotate               (eoi_rotate),
        .eoi_level                (eoi_level),
        .int_out                  (int_out),
        .data_out                 (data_out),
        .data_out_en              (data_out_en),
        .clear_irr                (clear_irr),
        .in_service_register      (isr),
        .highest_level_in_service (hlis),
        .ack_error                (ack_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    int eoi_rate = 0;

    // Reference model state: ISR bits and rotation point as a level number (-1 = fixed).
    logic [7:0] m_isr = 8'h00;
    int         m_rot = -1;
    int         cur_lvl = 0;
    bit         cur_spur = 1'b0;

    logic [7:0] q_clr[$];
    logic [7:0] q_vec[$];
    logic [7:0] q_err[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_hlis();
        return (m_rot < 0) ? 8'h00 : (8'h01 << m_rot);
    endfunction

    task automatic m_eoi(input bit sp, input bit rt, input int lv);
        int c;
        int idx;
        c = -1;
        if (sp) c = lv;
        else begin
            for (int k = 0; k < 8; k++) begin
                idx = (m_rot < 0) ? k : (m_rot + 1 + k) % 8;
                if (c < 0 && m_isr[idx]) c = idx;
            end
        end
        if (c >= 0) begin
            m_isr[c] = 1'b0;
            if (rt) m_rot = c;
        end
    endtask

    task automatic m_inta1(input bit spur, input int lvl);
        cur_spur = spur;
        cur_lvl  = spur ? 7 : lvl;
        if (!spur) begin
            m_isr[lvl] = 1'b1;
            q_clr.push_back(8'h01 << lvl);
        end
    endtask

    task automatic m_aeoi();
        if (auto_eoi && !cur_spur) begin
            m_isr[cur_lvl] = 1'b0;
            if (rotate_on_aeoi) m_rot = cur_lvl;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        eoi_valid = 1'b0;
    endtask

    task automatic drive_eoi(input bit sp, input bit rt, input int lv);
        eoi_valid    = 1'b1;
        eoi_specific = sp;
        eoi_rotate   = rt;
        eoi_level    = 3'(lv);
        m_eoi(sp, rt, lv);
    endtask

    task automatic maybe_eoi();
        if (eoi_rate > 0 && $urandom_range(0, 99) < eoi_rate)
            drive_eoi(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inta_n = 1'b1; interrupt = 8'h00; eoi_valid = 1'b0;
        cyc();
        chk("reset_outputs", {int_out, data_out, data_out_en, clear_irr, isr, hlis, ack_error}, 64'h0);
        m_isr = 8'h00;
        m_rot = -1;
        rst_n = 1'b1;
    endtask

    // Full acknowledge cycle starting from IDLE; eoi_at1 >= 0 forces a specific EOI at INTA1.
    task automatic run_txn(input int lvl, input bit spur, input int eoi_at1);
        interrupt = 8'h01 << lvl;
        maybe_eoi();
        cyc();
        chk("int_out_req", int_out, 1);
        inta_n = 1'b0;
        if (spur) interrupt = 8'h00;
        if (eoi_at1 >= 0) drive_eoi(1'b1, 1'b0, eoi_at1);
        else              maybe_eoi();
        m_inta1(spur, lvl);
        cyc();
        chk("int_out_ack1", int_out, 1);
        chk("isr_ack1", isr, m_isr);
        interrupt = 8'h00;
        repeat ($urandom_range(0, 2)) begin maybe_eoi(); cyc(); end
        inta_n = 1'b1;
        maybe_eoi();
        cyc();
        chk("int_out_rel", int_out, 0);
        repeat ($urandom_range(0, 2)) begin maybe_eoi(); cyc(); end
        inta_n = 1'b0;
        maybe_eoi();
        q_vec.push_back({vector_base, 3'(cur_lvl)});
        cyc();
        chk("data_en_ack2", data_out_en, 1);
        repeat ($urandom_range(0, 2)) begin maybe_eoi(); cyc(); end
        inta_n = 1'b1;
        maybe_eoi();
        m_aeoi();
        cyc();
        chk("data_en_done", {data_out_en, data_out, int_out}, 0);
        chk("isr_done", isr, m_isr);
        chk("hlis_done", hlis, m_hlis());
    endtask

    // Monitor: every DUT-presented event must match the next queued expectation.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (clear_irr !== 8'h00) begin
                if (q_clr.size() == 0) chk("clear_irr_unexpected", clear_irr, 8'h00);
                else                   chk("clear_irr", clear_irr, q_clr.pop_front());
            end
            if (data_out_en === 1'b1 && prev_en !== 1'b1) begin
                if (q_vec.size() == 0) chk("vector_unexpected", data_out_en, 0);
                else                   chk("vector", data_out, q_vec.pop_front());
            end
            if (ack_error === 1'b1) begin
                if (q_err.size() == 0) chk("ack_error_unexpected", ack_error, 0);
                else                   chk("ack_error_isr", isr, q_err.pop_front());
            end
        end
        prev_en <= data_out_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        mon_en = 1'b1;

        // T1: basic cycle, vector 0x42.
        vector_base = 5'h08; auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
        run_txn(2, 1'b0, -1);
        chk("t1_isr", isr, 8'h04);

        // T2: non-specific EOI under fixed and rotated priority.
        do_reset();
        run_txn(2, 1'b0, -1);
        run_txn(4, 1'b0, -1);
        chk("t2_isr14", isr, 8'h14);
        drive_eoi(1'b0, 1'b0, 0); cyc();
        chk("t2_ns_fixed", isr, 8'h10);
        drive_eoi(1'b1, 1'b1, 2); cyc();
        chk("t2_rot_clear_bit", hlis, 8'h04);
        run_txn(2, 1'b0, -1);
        drive_eoi(1'b0, 1'b1, 0); cyc();
        chk("t2_ns_rot_isr", isr, 8'h04);
        chk("t2_ns_rot_hlis", hlis, 8'h10);

        // T3: automatic EOI with rotation.
        do_reset();
        auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
        run_txn(7, 1'b0, -1);
        chk("t3_isr", isr, 8'h00);
        chk("t3_hlis", hlis, 8'h80);
        auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;

        // T4: withdrawn request, then spurious acknowledge.
        do_reset();
        vector_base = 5'h1a;
        interrupt = 8'h10; cyc();
        chk("t4_int_up", int_out, 1);
        interrupt = 8'h00; cyc();
        chk("t4_int_withdrawn", int_out, 0);
        inta_n = 1'b0; cyc();
        inta_n = 1'b1; cyc();
        chk("t4_idle_inta", {data_out_en, int_out, isr}, 0);
        run_txn(4, 1'b1, -1);
        chk("t4_spur_isr", isr, 8'h00);

        // T5: missing INTA2 times out.
        do_reset();
        interrupt = 8'h20; cyc();
        inta_n = 1'b0; m_inta1(1'b0, 5); cyc();
        interrupt = 8'h00; inta_n = 1'b1;
        for (int k = 1; k <= TO; k++) cyc();
        chk("t5_no_err_early", ack_error, 0);
        q_err.push_back(8'h20);
        cyc();
        chk("t5_err_pulse", ack_error, 1);
        cyc();
        chk("t5_err_one_cycle", {ack_error, int_out, data_out_en}, 0);
        chk("t5_isr_kept", isr, 8'h20);
        run_txn(1, 1'b0, -1);
        chk("t5_after_isr", isr, 8'h22);

        // T6: reset inside ACK2, then same-edge specific EOI and INTA1 on level 3.
        do_reset();
        interrupt = 8'h08; cyc();
        inta_n = 1'b0; m_inta1(1'b0, 3); cyc();
        interrupt = 8'h00; inta_n = 1'b1; cyc();
        inta_n = 1'b0; q_vec.push_back({vector_base, 3'd3}); cyc();
        chk("t6_in_ack2", data_out_en, 1);
        do_reset();
        run_txn(3, 1'b0, -1);
        run_txn(3, 1'b0, 3);
        chk("t6_same_edge", isr, 8'h08);

        // Randomised traffic with interleaved EOIs.
        do_reset();
        eoi_rate = 30;
        for (int t = 0; t < 150; t++) begin
            vector_base    = 5'($urandom_range(0, 31));
            auto_eoi       = 1'($urandom_range(0, 1));
            rotate_on_aeoi = 1'($urandom_range(0, 1));
            run_txn(int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), -1);
            repeat ($urandom_range(0, 3)) begin maybe_eoi(); cyc(); end
            chk("rand_isr_idle", isr, m_isr);
        end
        eoi_rate = 0;
        repeat (3) cyc();
        chk("q_clr_empty", q_clr.size(), 0);
        chk("q_vec_empty", q_vec.size(), 0);
        chk("q_err_empty", q_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
